// File: rtl/mem_arbiter.sv
// Two-requester (fetch / data) arbiter for a single-ported memory, data priority by default.
// Define MEM_ARB_FAIR_EN to alternate grants when both requesters are pending.
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              ifReq,
  input  logic [ADDR_W-1:0] ifAddr,
  output logic [DATA_W-1:0] ifRdata,
  output logic              ifDone,
  input  logic              dReq,
  input  logic              dWe,
  input  logic [ADDR_W-1:0] dAddr,
  input  logic [DATA_W-1:0] dWdata,
  output logic [DATA_W-1:0] dRdata,
  output logic              dDone,
  output logic              memReq,
  output logic              memWe,
  output logic [ADDR_W-1:0] memAddr,
  output logic [DATA_W-1:0] memWdata,
  input  logic [DATA_W-1:0] memRdata,
  input  logic              memReady,
  output logic              StallIF,
  output logic              StallMEM
);

  typedef enum logic [1:0] {IDLE, GRANT_D, GRANT_IF} state_t;
  state_t state;
  logic   pickD;

`ifdef MEM_ARB_FAIR_EN
  logic lastD;
  // Yield to a pending fetch when the previous grant went to data.
  assign pickD = dReq & (~ifReq | ~lastD);
`else
  assign pickD = dReq;
`endif

  assign StallIF  = ifReq & ~ifDone;
  assign StallMEM = dReq & ~dDone;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      memReq   <= 1'b0;
      memWe    <= 1'b0;
      memAddr  <= '0;
      memWdata <= '0;
      ifRdata  <= '0;
      dRdata   <= '0;
      ifDone   <= 1'b0;
      dDone    <= 1'b0;
`ifdef MEM_ARB_FAIR_EN
      lastD    <= 1'b0;
`endif
    end else begin
      ifDone <= 1'b0;
      dDone  <= 1'b0;
      case (state)
        IDLE: begin
          if (pickD) begin
            state    <= GRANT_D;
            memReq   <= 1'b1;
            memWe    <= dWe;
            memAddr  <= dAddr;
            memWdata <= dWdata;
`ifdef MEM_ARB_FAIR_EN
            lastD    <= 1'b1;
`endif
          end else if (ifReq) begin
            state    <= GRANT_IF;
            memReq   <= 1'b1;
            memWe    <= 1'b0;
            memAddr  <= ifAddr;
            memWdata <= dWdata;
`ifdef MEM_ARB_FAIR_EN
            lastD    <= 1'b0;
`endif
          end
        end
        GRANT_D: begin
          if (memReady) begin
            state  <= IDLE;
            memReq <= 1'b0;
            dDone  <= 1'b1;
            if (!memWe) dRdata <= memRdata;
          end
        end
        GRANT_IF: begin
          if (memReady) begin
            state   <= IDLE;
            memReq  <= 1'b0;
            ifDone  <= 1'b1;
            ifRdata <= memRdata;
          end
        end
        default: begin
          state  <= IDLE;
          memReq <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stimulus pushes expected completions, a monitor pops on Done.
module tb_mem_arbiter;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        ifReq, dReq, dWe, memReady;
  logic [31:0] ifAddr, dAddr, dWdata, memRdata;
  logic [31:0] ifRdata, dRdata, memAddr, memWdata;
  logic        ifDone, dDone, memReq, memWe, StallIF, StallMEM;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .reset_n(reset_n),
    .ifReq(ifReq), .ifAddr(ifAddr), .ifRdata(ifRdata), .ifDone(ifDone),
    .dReq(dReq), .dWe(dWe), .dAddr(dAddr), .dWdata(dWdata), .dRdata(dRdata), .dDone(dDone),
    .memReq(memReq), .memWe(memWe), .memAddr(memAddr), .memWdata(memWdata),
    .memRdata(memRdata), .memReady(memReady), .StallIF(StallIF), .StallMEM(StallMEM)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        isD;
    logic [31:0] data;
  } exp_t;

  exp_t sbq[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Completion monitor: every Done pulse must match the oldest expected completion.
  always @(negedge clk) begin
    if (reset_n === 1'b1 && (dDone || ifDone)) begin
      if (sbq.size() == 0) begin
        chk("unexpected_done", {30'd0, dDone, ifDone}, 32'd0);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("done_owner", {31'd0, dDone}, {31'd0, e.isD});
        chk("done_single", {31'd0, dDone & ifDone}, 32'd0);
        if (e.isD) chk("dRdata", dRdata, e.data);
        else       chk("ifRdata", ifRdata, e.data);
      end
    end
  end

  initial begin
    int n;
    reset_n = 1'b0;
    ifReq = 0; dReq = 0; dWe = 0; memReady = 0;
    ifAddr = 0; dAddr = 0; dWdata = 0; memRdata = 0;

    // Reset state
    #12;
    chk("rst_memReq", {31'd0, memReq}, 32'd0);
    chk("rst_memWe", {31'd0, memWe}, 32'd0);
    chk("rst_memAddr", memAddr, 32'd0);
    chk("rst_memWdata", memWdata, 32'd0);
    chk("rst_dRdata", dRdata, 32'd0);
    chk("rst_ifRdata", ifRdata, 32'd0);
    chk("rst_dones", {30'd0, dDone, ifDone}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    memReady = 1'b1;  // ignored while idle
    @(negedge clk);
    chk("idle_memReq", {31'd0, memReq}, 32'd0);

    // Single-cycle read
    dReq = 1; dWe = 0; dAddr = 32'h40; memRdata = 32'hDEADBEEF;
    sbq.push_back('{1'b1, 32'hDEADBEEF});
    #1 chk("rd_stallmem_pre", {31'd0, StallMEM}, 32'd1);
    @(negedge clk);
    chk("rd_memReq", {31'd0, memReq}, 32'd1);
    chk("rd_memAddr", memAddr, 32'h40);
    chk("rd_memWe", {31'd0, memWe}, 32'd0);
    chk("rd_stallmem", {31'd0, StallMEM}, 32'd1);
    @(negedge clk);
    chk("rd_dDone", {31'd0, dDone}, 32'd1);
    chk("rd_memReq_off", {31'd0, memReq}, 32'd0);
    chk("rd_stallmem_done", {31'd0, StallMEM}, 32'd0);
    dReq = 0; memReady = 0;
    @(negedge clk);
    chk("rd_dDone_pulse", {31'd0, dDone}, 32'd0);

    // Store with three wait cycles; inputs scrambled after grant must not leak through
    dReq = 1; dWe = 1; dAddr = 32'h80; dWdata = 32'h12345678;
    sbq.push_back('{1'b1, 32'hDEADBEEF});
    @(negedge clk);
    dAddr = 32'hFFFF_0000; dWdata = 32'h0; dWe = 0;
    for (int i = 0; i < 4; i++) begin
      chk("st_memReq", {31'd0, memReq}, 32'd1);
      chk("st_memWe", {31'd0, memWe}, 32'd1);
      chk("st_memAddr", memAddr, 32'h80);
      chk("st_memWdata", memWdata, 32'h12345678);
      chk("st_no_done", {31'd0, dDone}, 32'd0);
      if (i == 3) memReady = 1;
      @(negedge clk);
    end
    chk("st_dDone", {31'd0, dDone}, 32'd1);
    dReq = 0; memReady = 0;
    @(negedge clk);

    // Contention: data first, fetch completes exactly two cycles after data
    ifReq = 1; ifAddr = 32'h0; dReq = 1; dWe = 0; dAddr = 32'h100;
    memReady = 1; memRdata = 32'hA5A5A5A5;
    sbq.push_back('{1'b1, 32'hA5A5A5A5});
    sbq.push_back('{1'b0, 32'h0BADF00D});
    @(negedge clk);
    chk("ct_memAddr_d", memAddr, 32'h100);
    chk("ct_stallif", {31'd0, StallIF}, 32'd1);
    @(negedge clk);
    chk("ct_dDone", {31'd0, dDone}, 32'd1);
    dReq = 0; memRdata = 32'h0BADF00D;
    @(negedge clk);
    chk("ct_memReq_if", {31'd0, memReq}, 32'd1);
    chk("ct_memAddr_if", memAddr, 32'h0);
    chk("ct_memWe_if", {31'd0, memWe}, 32'd0);
    chk("ct_ifDone_early", {31'd0, ifDone}, 32'd0);
    @(negedge clk);
    chk("ct_ifDone", {31'd0, ifDone}, 32'd1);
    chk("ct_stallif_done", {31'd0, StallIF}, 32'd0);
    chk("ct_dRdata_kept", dRdata, 32'hA5A5A5A5);
    ifReq = 0; memReady = 0;
    @(negedge clk);

    // Both requests held: strict priority starves fetch, fairness alternates
    dAddr = 32'h300; dWe = 0; ifAddr = 32'h400; memRdata = 32'hC0DE0001; memReady = 1;
`ifdef MEM_ARB_FAIR_EN
    sbq.push_back('{1'b1, 32'hC0DE0001}); sbq.push_back('{1'b0, 32'hC0DE0001});
    sbq.push_back('{1'b1, 32'hC0DE0001}); sbq.push_back('{1'b0, 32'hC0DE0001});
`else
    for (int i = 0; i < 4; i++) sbq.push_back('{1'b1, 32'hC0DE0001});
`endif
    dReq = 1; ifReq = 1;
    n = 0;
    for (int c = 0; c < 30 && n < 4; c++) begin
      @(negedge clk);
      if (dDone || ifDone) n++;
    end
    chk("fair_done_count", n, 32'd4);
    dReq = 0; ifReq = 0; memReady = 0;
    @(negedge clk);

    // Reset mid-fetch-grant aborts without Done
    ifReq = 1; ifAddr = 32'h200;
    @(negedge clk);
    chk("rg_memReq", {31'd0, memReq}, 32'd1);
    chk("rg_memAddr", memAddr, 32'h200);
    #2 reset_n = 1'b0;
    #1;
    chk("rg_memReq_async", {31'd0, memReq}, 32'd0);
    chk("rg_memAddr_async", memAddr, 32'd0);
    chk("rg_ifRdata_async", ifRdata, 32'd0);
    ifReq = 0;
    @(negedge clk);
    reset_n = 1'b1;
    memReady = 1;
    repeat (2) begin
      @(negedge clk);
      chk("rg_idle_memReq", {31'd0, memReq}, 32'd0);
      chk("rg_no_ifDone", {31'd0, ifDone}, 32'd0);
    end

    // Operation resumes after reset
    dReq = 1; dWe = 0; dAddr = 32'h44; memRdata = 32'h5555AAAA;
    sbq.push_back('{1'b1, 32'h5555AAAA});
    @(negedge clk);
    chk("pr_memAddr", memAddr, 32'h44);
    @(negedge clk);
    chk("pr_dDone", {31'd0, dDone}, 32'd1);
    dReq = 0; memReady = 0;
    repeat (3) @(negedge clk);

    chk("sb_empty", sbq.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
